// File: rtl/matrix_link_rx.sv
// Loopback receiver for the LED-matrix link: oversamples the multi-lane SPI bus and the
// 595-style column bus in the clk domain and rebuilds the data words and latched column word.
module matrix_link_rx #(
  parameter int unsigned CHANNEL_NUMBER = 3,
  parameter int unsigned SPI_SIZE       = 8,
  parameter int unsigned MSB_FIRST      = 1,
  parameter int unsigned COLUMNS        = 16,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               spi_clk_in,
  input  logic [CHANNEL_NUMBER-1:0]          spi_mosi_in,
  input  logic                               ser_clk_in,
  input  logic                               ser_data_in,
  input  logic                               ser_stcp_in,
  input  logic                               ser_n_enable_in,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
  output logic                               data_valid,
  output logic                               frame_error,
  output logic [COLUMNS-1:0]                 col_latch,
  output logic                               col_valid,
  output logic [$clog2(COLUMNS)-1:0]         col_index,
  output logic                               col_onehot_ok,
  output logic                               outputs_enabled
);

  localparam int unsigned BitW  = $clog2(SPI_SIZE);
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW  = $clog2(COLUMNS);
  localparam int unsigned WordW = CHANNEL_NUMBER * SPI_SIZE;

  typedef enum logic {StIdle, StShift} spi_state_e;

  logic                      spi_clk_s1, spi_clk_s2, spi_clk_s3;
  logic [CHANNEL_NUMBER-1:0] mosi_s1, mosi_s2;
  logic                      ser_clk_s1, ser_clk_s2, ser_clk_s3;
  logic                      ser_data_s1, ser_data_s2;
  logic                      stcp_s1, stcp_s2, stcp_s3;
  logic                      n_en_s1, n_en_s2;

  logic spi_rise, ser_rise, stcp_rise;

  spi_state_e      state_q, state_d;
  logic [BitW-1:0] bit_cnt_q;
  logic [CntW-1:0] idle_cnt_q;
  logic [WordW-1:0] sr_q, sr_d;
  logic            word_done_q;
  logic            last_bit, timeout_hit, word_end, abort;

  logic [COLUMNS-1:0] col_sr_q;
  logic [IdxW-1:0]    idx_d;
  logic               onehot_d;

  // Synchronizers; the enable chain resets to the inactive (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_clk_s1  <= 1'b0;
      spi_clk_s2  <= 1'b0;
      spi_clk_s3  <= 1'b0;
      mosi_s1     <= '0;
      mosi_s2     <= '0;
      ser_clk_s1  <= 1'b0;
      ser_clk_s2  <= 1'b0;
      ser_clk_s3  <= 1'b0;
      ser_data_s1 <= 1'b0;
      ser_data_s2 <= 1'b0;
      stcp_s1     <= 1'b0;
      stcp_s2     <= 1'b0;
      stcp_s3     <= 1'b0;
      n_en_s1     <= 1'b1;
      n_en_s2     <= 1'b1;
    end else begin
      spi_clk_s1  <= spi_clk_in;
      spi_clk_s2  <= spi_clk_s1;
      spi_clk_s3  <= spi_clk_s2;
      mosi_s1     <= spi_mosi_in;
      mosi_s2     <= mosi_s1;
      ser_clk_s1  <= ser_clk_in;
      ser_clk_s2  <= ser_clk_s1;
      ser_clk_s3  <= ser_clk_s2;
      ser_data_s1 <= ser_data_in;
      ser_data_s2 <= ser_data_s1;
      stcp_s1     <= ser_stcp_in;
      stcp_s2     <= stcp_s1;
      stcp_s3     <= stcp_s2;
      n_en_s1     <= ser_n_enable_in;
      n_en_s2     <= n_en_s1;
    end
  end

  assign spi_rise  = spi_clk_s2 & ~spi_clk_s3;
  assign ser_rise  = ser_clk_s2 & ~ser_clk_s3;
  assign stcp_rise = stcp_s2 & ~stcp_s3;

  assign outputs_enabled = ~n_en_s2;

  assign last_bit    = (bit_cnt_q == BitW'(SPI_SIZE - 1));
  assign timeout_hit = (idle_cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (spi_rise) state_d = StShift;
      StShift: begin
        if (spi_rise) begin
          if (last_bit) state_d = StIdle;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A rise coinciding with the timeout wins, so abort requires no rise.
  always_comb begin
    word_end = (state_q == StShift) && spi_rise && last_bit;
    abort    = (state_q == StShift) && !spi_rise && timeout_hit;
  end

  always_comb begin
    sr_d = sr_q;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (MSB_FIRST != 0) begin
        sr_d[i*SPI_SIZE +: SPI_SIZE] = {sr_q[i*SPI_SIZE +: SPI_SIZE-1], mosi_s2[i]};
      end else begin
        sr_d[i*SPI_SIZE +: SPI_SIZE] = {mosi_s2[i], sr_q[i*SPI_SIZE+1 +: SPI_SIZE-1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      sr_q        <= '0;
      word_done_q <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      word_done_q <= word_end;
      data_valid  <= word_done_q;
      frame_error <= abort;
      if (word_done_q) data_out <= sr_q;
      if (spi_rise) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != CntW'(TIMEOUT)) begin
        idle_cnt_q <= idle_cnt_q + CntW'(1);
      end
      if (spi_rise) begin
        sr_q      <= sr_d;
        bit_cnt_q <= word_end ? '0 : bit_cnt_q + BitW'(1);
      end else if (abort) begin
        bit_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    idx_d = '0;
    for (int i = COLUMNS - 1; i >= 0; i--) begin
      if (col_latch[i]) idx_d = IdxW'(i);
    end
    onehot_d = (col_latch != '0) && ((col_latch & (col_latch - COLUMNS'(1))) == '0);
  end

  // Latch reads the pre-shift register when shift and store clocks rise together.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_sr_q      <= '0;
      col_latch     <= '0;
      col_valid     <= 1'b0;
      col_index     <= '0;
      col_onehot_ok <= 1'b0;
    end else begin
      if (ser_rise)  col_sr_q  <= {col_sr_q[COLUMNS-2:0], ser_data_s2};
      if (stcp_rise) col_latch <= col_sr_q;
      col_valid     <= stcp_rise;
      col_index     <= idx_d;
      col_onehot_ok <= onehot_d;
    end
  end

endmodule
